// File: rtl/gpio_bank_if.sv
// ----------------------------------------------------------------------------
// gpio_bank_if
//   Register/bus-side signal bundle of the GPIO bank. The master side is the
//   register logic; the slave side is the GPIO bank itself.
//
//   en          master->slave  block enable (0 freezes the bank)
//   dir_we      master->slave  load dir_in into the direction register
//   dir_in      master->slave  per-bit direction, 1 = drive pad
//   out_we      master->slave  load data_in into the output register
//   data_in     master->slave  value driven on output-mode pads
//   evt_mask    master->slave  per-bit enable of edge events into status
//   status_clr  master->slave  write-1-to-clear for status bits
//   data_out    slave->master  debounced pad levels
//   rise/fall   slave->master  one-cycle edge pulses of the debounced levels
//   status      slave->master  sticky event flags
//   irq         slave->master  registered OR of status
// ----------------------------------------------------------------------------
interface gpio_bank_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             dir_we;
  logic [WIDTH-1:0] dir_in;
  logic             out_we;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] evt_mask;
  logic [WIDTH-1:0] status_clr;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] status;
  logic             irq;

  modport master (
    output en, dir_we, dir_in, out_we, data_in, evt_mask, status_clr,
    input  data_out, rise, fall, status, irq
  );

  modport slave (
    input  en, dir_we, dir_in, out_we, data_in, evt_mask, status_clr,
    output data_out, rise, fall, status, irq
  );
endinterface

// File: rtl/gpio_bank.sv
// ----------------------------------------------------------------------------
// gpio_bank
//   Multi-channel bidirectional GPIO bank. Every channel has a registered
//   direction and output value driving a tri-state pad, and an input path of
//   synchroniser -> debounce filter -> edge detector. Edge events, gated by a
//   per-bit mask, set sticky status flags whose OR is a registered interrupt.
//
//   clk      in     system clock, rising edge
//   rst      in     asynchronous reset, active-high; clears all state
//   bus      slave  register-side bundle (see gpio_bank_if)
//   io_port  inout  WIDTH pads; driven only where the direction bit is 1
// ----------------------------------------------------------------------------
module gpio_bank #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  gpio_bank_if.slave        bus,
  inout  wire  [WIDTH-1:0]  io_port
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Configuration registers
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_out;

  // Input path state
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_deb;
  logic [CNT_W-1:0] r_cnt  [WIDTH];

  // Event / interrupt state
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_status;
  logic             r_irq;

  // Combinational next-state of the debounce filter
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_deb_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

  // --------------------------------------------------------------------------
  // Configuration registers: writes only take effect while the bank is enabled
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir <= '0;
      r_out <= '0;
    end else if (bus.en) begin
      if (bus.dir_we) r_dir <= bus.dir_in;
      if (bus.out_we) r_out <= bus.data_in;
    end
  end

  // --------------------------------------------------------------------------
  // Pad drivers: combinational from the registers, so reset releases the pads
  // immediately without waiting for a clock edge.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pad
    assign io_port[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
  end

  // --------------------------------------------------------------------------
  // Synchroniser: the whole pad vector (outputs included, for read-back)
  // shifts through SYNC_STAGES flops. Holds while disabled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else if (bus.en) begin
      r_sync[0] <= io_port;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Debounce: a bit's counter runs while the synchronised level differs from
  // the accepted level and restarts whenever they agree, so only a level held
  // for DEBOUNCE_CYCLES consecutive samples is accepted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_deb_nxt = r_deb;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_s[i] == r_deb[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_deb_nxt[i] = w_s[i];
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else if (bus.en) begin
      r_deb <= w_deb_nxt;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // --------------------------------------------------------------------------
  // Edge pulses: registered from the same next-state as r_deb, so a pulse is
  // high exactly during the cycle in which data_out shows the new level.
  // Forced low while disabled so a frozen bank never reports an edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= '0;
      r_fall <= '0;
    end else if (bus.en) begin
      r_rise <= w_deb_nxt & ~r_deb;
      r_fall <= ~w_deb_nxt & r_deb;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky status and interrupt: not gated by en so software can still clear
  // flags on a disabled bank. A new event in the clear cycle keeps the bit set.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= (r_status & ~bus.status_clr) | ((r_rise | r_fall) & bus.evt_mask);
      r_irq    <= |r_status;
    end
  end

  assign bus.data_out = r_deb;
  assign bus.rise     = r_rise;
  assign bus.fall     = r_fall;
  assign bus.status   = r_status;
  assign bus.irq      = r_irq;

endmodule

// File: tb/tb_gpio_bank.sv
// ----------------------------------------------------------------------------
// tb_gpio_bank
//   Directed bench for gpio_bank (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
//   Stimulus queues the expected debounced edge events; a monitor pops one
//   each time the DUT shows a rise/fall pulse and compares pulse and level.
//   Static values (pads, status, irq, levels) are checked inline.
// ----------------------------------------------------------------------------
module tb_gpio_bank;

  logic clk = 1'b0;
  logic rst;

  gpio_bank_if #(.WIDTH(8)) bus ();

  wire  [7:0] io_port;
  logic [7:0] tb_oe;
  logic [7:0] tb_val;

  for (genvar gi = 0; gi < 8; gi++) begin : g_tbpad
    assign io_port[gi] = tb_oe[gi] ? tb_val[gi] : 1'bz;
  end

  gpio_bank #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .io_port(io_port)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] f;
  } evt_t;

  evt_t exp_q[$];
  evt_t mon_e;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] r, input logic [7:0] f);
    evt_t e;
    e.d = d;
    e.r = r;
    e.f = f;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed edge pulse must match the next expected event
  always @(negedge clk) begin
    if (!rst && ((bus.rise | bus.fall) != 8'h00)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_edge: rise=%02h fall=%02h data_out=%02h with none expected at %0t",
                 bus.rise, bus.fall, bus.data_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("edge_rise", bus.rise, mon_e.r);
        check("edge_fall", bus.fall, mon_e.f);
        check("edge_data_out", bus.data_out, mon_e.d);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.en         = 1'b1;
    bus.dir_we     = 1'b0;
    bus.dir_in     = 8'h00;
    bus.out_we     = 1'b0;
    bus.data_in    = 8'h00;
    bus.evt_mask   = 8'h00;
    bus.status_clr = 8'h00;
    tb_oe          = 8'hFF;
    tb_val         = 8'hA5;

    // 1. Reset with pads pulled to A5
    #12;
    check("reset_pads_released", io_port, 8'hA5);
    check("reset_data_out", bus.data_out, 8'h00);
    check("reset_status", bus.status, 8'h00);
    check("reset_irq", {7'b0, bus.irq}, 8'h00);
    check("reset_rise", bus.rise, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(8'hA5, 8'hA5, 8'h00);
    tick(5);
    check("latency_not_early", bus.data_out, 8'h00);
    tick(1);
    check("latency_6clk", bus.data_out, 8'hA5);

    // 2. Output write; tb hands the low nibble over to the DUT
    bus.dir_we  = 1'b1;
    bus.dir_in  = 8'h0F;
    bus.out_we  = 1'b1;
    bus.data_in = 8'h05;
    tick(1);
    bus.dir_we = 1'b0;
    bus.out_we = 1'b0;
    tb_oe      = 8'hF0;
    check("out_write_pads", io_port, 8'hA5);
    tick(6);
    check("out_readback_same", bus.data_out, 8'hA5);
    bus.out_we  = 1'b1;
    bus.data_in = 8'h0A;
    push(8'hAA, 8'h0A, 8'h05);
    tick(1);
    bus.out_we = 1'b0;
    check("out_write2_pads", io_port, 8'hAA);
    tick(5);
    check("out_readback_early", bus.data_out, 8'hA5);
    tick(1);
    check("out_readback_new", bus.data_out, 8'hAA);

    // 3. Debounce on bit0 as an input
    tb_oe      = 8'hF1;
    tb_val     = 8'hA0;
    bus.dir_we = 1'b1;
    bus.dir_in = 8'h0E;
    tick(1);
    bus.dir_we = 1'b0;
    check("bit0_input_pads", io_port, 8'hAA);
    tb_val = 8'hA1;
    tick(3);
    tb_val = 8'hA0;
    tick(8);
    check("glitch_3clk_filtered", bus.data_out, 8'hAA);
    push(8'hAB, 8'h01, 8'h00);
    push(8'hAA, 8'h00, 8'h01);
    tb_val = 8'hA1;
    tick(4);
    tb_val = 8'hA0;
    tick(2);
    check("pulse_4clk_accepted", bus.data_out, 8'hAB);

    // 4. Status/irq: masked rise does not set status, fall does
    tick(1);
    bus.evt_mask = 8'h01;
    tick(3);
    check("fall_level", bus.data_out, 8'hAA);
    check("status_unmasked_rise", bus.status, 8'h00);
    tick(1);
    check("status_on_fall", bus.status, 8'h01);
    check("irq_lags_status", {7'b0, bus.irq}, 8'h00);
    tick(1);
    check("irq_set", {7'b0, bus.irq}, 8'h01);
    push(8'hAB, 8'h01, 8'h00);
    tb_val = 8'hA1;
    tick(6);
    check("rise_level", bus.data_out, 8'hAB);
    bus.status_clr = 8'h01;
    tick(1);
    check("set_beats_clear", bus.status, 8'h01);
    tick(1);
    bus.status_clr = 8'h00;
    check("status_cleared", bus.status, 8'h00);
    check("irq_still_set", {7'b0, bus.irq}, 8'h01);
    tick(1);
    check("irq_cleared", {7'b0, bus.irq}, 8'h00);

    // 5. Enable freeze with cnt=2
    push(8'hAA, 8'h00, 8'h01);
    tb_val = 8'hA0;
    tick(4);
    bus.en     = 1'b0;
    bus.dir_we = 1'b1;
    bus.dir_in = 8'h00;
    tick(1);
    bus.dir_we = 1'b0;
    tick(4);
    check("freeze_data_out", bus.data_out, 8'hAB);
    check("freeze_dir_ignored", io_port, 8'hAA);
    bus.en = 1'b1;
    tick(1);
    check("resume_cnt3", bus.data_out, 8'hAB);
    tick(1);
    check("resume_update", bus.data_out, 8'hAA);
    tick(1);
    check("freeze_fall_status", bus.status, 8'h01);
    bus.en         = 1'b0;
    bus.status_clr = 8'h01;
    tick(1);
    check("clear_while_disabled", bus.status, 8'h00);
    bus.status_clr = 8'h00;
    bus.en         = 1'b1;
    tick(2);

    // 6. Async reset mid-debounce
    tb_val = 8'hA1;
    tick(3);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_data_out", bus.data_out, 8'h00);
    check("async_rst_status", bus.status, 8'h00);
    check("async_rst_irq", {7'b0, bus.irq}, 8'h00);
    tb_oe  = 8'hFF;
    tb_val = 8'hF1;
    #1;
    check("async_rst_pads_released", io_port, 8'hF1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(8'hF1, 8'hF1, 8'h00);
    tick(5);
    check("rst_cnt_discarded", bus.data_out, 8'h00);
    tick(1);
    check("rst_relatch", bus.data_out, 8'hF1);

    tick(10);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d outstanding expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
